// File: rtl/lmul.sv
// lmul: iterative signed multiply-accumulate, result = quotient * denominator + remainder.
// Optional LMUL_EARLY_TERM_EN: MUL exits once the shifted multiplier runs out of set bits.
module lmul #(
  parameter int QUOTIENT_WIDTH    = 24,
  parameter int DENOMINATOR_WIDTH = 20,
  parameter int NUMERATOR_WIDTH   = 24,
  localparam int RESULT_WIDTH     =
    QUOTIENT_WIDTH + DENOMINATOR_WIDTH + 1
) (
  input  logic                         clk,
  input  logic                         resetb,
  input  logic [QUOTIENT_WIDTH-1:0]    quotient_in,
  input  logic [DENOMINATOR_WIDTH-1:0] denominator_in,
  input  logic [NUMERATOR_WIDTH-1:0]   remainder_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [RESULT_WIDTH-1:0]      result_out,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int QW = QUOTIENT_WIDTH;
  localparam int RW = RESULT_WIDTH;
  localparam int CW = $clog2(QUOTIENT_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    FIXUP,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [QW-1:0]   mplier_q, mplier_d;
  logic [RW-1:0]   mcand_q, mcand_d;
  logic [RW-1:0]   acc_q, acc_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [RW-1:0]   result_q, result_d;
  logic [CW-1:0]   count_q, count_d;
  logic            neg_q, neg_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic [QW-1:0]   q_abs;
  logic            accept;
  logic            mul_last;

  // Magnitude of the quotient; the most negative value maps to 2^(Q-1) unsigned.
  always_comb begin
    q_abs = quotient_in;
    if (quotient_in[QW-1]) begin
      q_abs = ~quotient_in + QW'(1);
    end
  end

  assign accept = in_valid & in_ready_q;

  // Last shift-add step: fixed count, or early once no multiplier bits remain.
  always_comb begin
    mul_last = (count_q == CW'(QW-1));
`ifdef LMUL_EARLY_TERM_EN
    if (mplier_q[QW-1:1] == '0) begin
      mul_last = 1'b1;
    end
`else
    mul_last = mul_last;
`endif
  end

  // Next-state and datapath update for the shift-add sequencer.
  always_comb begin
    state_d     = state_q;
    mplier_d    = mplier_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    result_d    = result_q;
    count_d     = count_q;
    neg_d       = neg_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (accept) begin
          mplier_d   = q_abs;
          mcand_d    = RW'(denominator_in);
          acc_d      = '0;
          neg_d      = quotient_in[QW-1];
          rem_d      = RW'($signed(remainder_in));
          count_d    = '0;
          in_ready_d = 1'b0;
          state_d    = MUL;
`ifdef LMUL_EARLY_TERM_EN
          if (q_abs == '0) begin
            state_d = FIXUP;
          end
`endif
        end
      end
      MUL: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
        if (mul_last) begin
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        result_d    = (neg_q ? -acc_q : acc_q) + rem_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q     <= IDLE;
      mplier_q    <= '0;
      mcand_q     <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      result_q    <= '0;
      count_q     <= '0;
      neg_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mplier_q    <= mplier_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      result_q    <= result_d;
      count_q     <= count_d;
      neg_q       <= neg_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign result_out = result_q;

endmodule

// File: tb/tb_lmul.sv
// tb_lmul: vector table, directed corner sequences and random ops
// checked against an arithmetic model of q*d+r and the expected latency.
module tb_lmul;

  localparam int Q  = 24;
  localparam int D  = 20;
  localparam int N  = 24;
  localparam int RW = Q + D + 1;

  logic          clk = 1'b0;
  logic          resetb = 1'b0;
  logic [Q-1:0]  quotient_in = '0;
  logic [D-1:0]  denominator_in = '0;
  logic [N-1:0]  remainder_in = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [RW-1:0] result_out;
  logic          out_valid;
  logic          out_ready = 1'b1;

  int compared = 0;
  int mismatched = 0;

  lmul #(
    .QUOTIENT_WIDTH(Q),
    .DENOMINATOR_WIDTH(D),
    .NUMERATOR_WIDTH(N)
  ) dut (
    .clk(clk),
    .resetb(resetb),
    .quotient_in(quotient_in),
    .denominator_in(denominator_in),
    .remainder_in(remainder_in),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .result_out(result_out),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     q;
    int     d;
    int     r;
    longint res;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input longint act,
                     input longint exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint res_now();
    logic signed [RW-1:0] s;
    s = result_out;
    return longint'(s);
  endfunction

  function automatic int exp_lat(input int q);
    longint a;
    int hb;
    a = (q < 0) ? -longint'(q) : longint'(q);
    hb = -1;
    for (int i = 0; i < Q; i++) begin
      if (a[i]) hb = i;
    end
`ifdef LMUL_EARLY_TERM_EN
    return (hb < 0) ? 1 : hb + 2;
`else
    return (hb < -2) ? 0 : Q + 1;
`endif
  endfunction

  function automatic longint model(input int q, input int d,
                                   input int r);
    return longint'(q) * longint'(d) + longint'(r);
  endfunction

  task automatic drive(input int q, input int d, input int r);
    quotient_in    = q[Q-1:0];
    denominator_in = d[D-1:0];
    remainder_in   = r[N-1:0];
  endtask

  // Called #1 after the accept edge; counts edges until out_valid.
  task automatic wait_valid(output int lat, output bit rdy_seen);
    lat = 0;
    rdy_seen = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_seen = 1;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic do_op(input string name, input int q, input int d,
                       input int r, input longint exp_res);
    int b;
    int lat;
    bit rs;
    drive(q, d, r);
    in_valid = 1'b1;
    out_ready = 1'b1;
    b = 0;
    while (!in_ready && b < 200) begin
      @(posedge clk);
      #1;
      b++;
    end
    if (b >= 200) chk({name, " ready_timeout"}, 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid(lat, rs);
    chk({name, " latency"}, lat, exp_lat(q));
    chk({name, " result"}, res_now(), exp_res);
    chk({name, " in_ready_busy"}, rs, 0);
    @(posedge clk);
    #1;
    chk({name, " out_valid_drop"}, out_valid, 0);
    chk({name, " in_ready_back"}, in_ready, 1);
  endtask

  initial begin
    int lat;
    bit rs;
    bit stable;
    logic signed [Q-1:0] qs;
    int q;
    int d;
    int r;

    vecs[0] = '{5, 7, 3, 38};
    vecs[1] = '{-5, 7, -3, -38};
    vecs[2] = '{-5, 7, 2, -33};
    vecs[3] = '{-8388608, 'hFFFFF, 0, -64'sd8796084633600};
    vecs[4] = '{0, 9, -4, -4};
    vecs[5] = '{1, 3, 0, 3};
    vecs[6] = '{123, 0, -77, -77};
    vecs[7] = '{8388607, 'hFFFFF, 8388607, 64'sd8796091973632};
    vecs[8] = '{-1, 1, -8388608, -8388609};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", in_ready, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst result", res_now(), 0);
    resetb = 1'b1;
    #1;
    chk("rel in_ready_pre", in_ready, 0);
    @(posedge clk);
    #1;
    chk("rel in_ready_post", in_ready, 1);

    foreach (vecs[i]) begin
      do_op($sformatf("vec%0d", i), vecs[i].q, vecs[i].d,
            vecs[i].r, vecs[i].res);
    end

    // Backpressure with a waiting request
    out_ready = 1'b0;
    drive(-5, 7, 2);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid(lat, rs);
    chk("bp latency", lat, exp_lat(-5));
    drive(6, 7, 1);
    in_valid = 1'b1;
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (!out_valid || in_ready || res_now() != -33) stable = 0;
    end
    chk("bp stable", stable, 1);
    chk("bp result", res_now(), -33);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp out_valid_drop", out_valid, 0);
    chk("bp in_ready_up", in_ready, 1);
    @(posedge clk);
    #1;
    chk("bp accepted", in_ready, 0);
    in_valid = 1'b0;
    wait_valid(lat, rs);
    chk("bp2 latency", lat, exp_lat(6));
    chk("bp2 result", res_now(), 43);
    @(posedge clk);
    #1;

    // Reset mid-operation
    drive(100, 3, 1);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    resetb = 1'b0;
    #1;
    chk("arst out_valid", out_valid, 0);
    chk("arst result", res_now(), 0);
    chk("arst in_ready", in_ready, 0);
    repeat (10) @(posedge clk);
    #1;
    stable = (out_valid == 1'b0);
    chk("arst hold", stable, 1);
    resetb = 1'b1;
    do_op("after_rst", 100, 3, 1, 301);

    // Random operands against the arithmetic model
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) begin
        qs = Q'($urandom);
      end else begin
        qs = Q'($signed($urandom_range(0, 31)) - 16);
      end
      q = int'(qs);
      d = int'($urandom_range(0, (1 << D) - 1));
      qs = Q'($urandom);
      r = int'(qs);
      do_op($sformatf("rnd%0d", k), q, d, r, model(q, d, r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
